// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: sizing helper,
// bit-reversal function and the read-side FSM state encoding.
package fft_pkg;

    localparam int unsigned MAX_AW = 10;
    localparam int unsigned BIT_IW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Reverses the low 'bits' bits of v; bits above that are returned as zero.
    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] v,
                                                 input int unsigned bits);
        logic [MAX_AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_AW; i++) begin
            if (i < bits) r[BIT_IW'(i)] = v[BIT_IW'(bits - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port sample store holding both ping-pong banks; the bank is the
// address MSB. Only the read data register is reset, never the array itself.
module reorder_ram #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read data holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_reorder.sv
// Converts bit-reversed FFT output frames into natural bin order using a
// ping-pong pair of frame banks; ovf latches any write into an unread bank.
module fft_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N     = 64,
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_re,
    input  logic [WIDTH-1:0]      in_im,
    input  logic                  rd_hold,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_re,
    output logic [WIDTH-1:0]      out_im,
    output logic [clog2(N)-1:0]   out_idx,
    output logic                  out_last,
    output logic                  ovf
);

    localparam int unsigned AW = clog2(N);
    localparam int unsigned DW = 2 * WIDTH;

    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic          wbank;
    logic          rbank;
    logic [1:0]    full;
    rd_state_t     state;
    rd_state_t     state_nxt;
    logic          rd_en_c;
    logic          rd_done_c;
    logic          wr_en_c;
    logic          wr_wrap_c;
    logic [AW-1:0] wr_addr_nat;
    logic [DW-1:0] rd_data;

    assign wr_en_c     = in_valid && !full[wbank];
    assign wr_wrap_c   = wr_en_c && (wcnt == AW'(N - 1));
    assign wr_addr_nat = AW'(bitrev(MAX_AW'(wcnt), AW));

    // Write side: arrival count maps to natural bin via bit reversal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (wr_en_c) begin
            wcnt <= wcnt + AW'(1);
            if (wr_wrap_c) wbank <= ~wbank;
        end
    end

    // Writer and reader always touch different banks, so both updates apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (rd_done_c) full[rbank] <= 1'b0;
            if (wr_wrap_c) full[wbank] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      ovf <= 1'b0;
        else if (in_valid && full[wbank]) ovf <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt  <= '0;
            rbank <= 1'b0;
        end else if (rd_en_c) begin
            rcnt <= rcnt + AW'(1);
            if (rd_done_c) rbank <= ~rbank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rbank] && !rd_hold) state_nxt = READ;
            READ:    if (rd_done_c) state_nxt = full[~rbank] ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first read of a frame is issued from IDLE so a back-to-back frame
    // follows the previous one without a bubble.
    always_comb begin
        rd_en_c   = 1'b0;
        rd_done_c = 1'b0;
        if (!rd_hold) begin
            case (state)
                IDLE:    rd_en_c = full[rbank];
                READ:    rd_en_c = 1'b1;
                default: rd_en_c = 1'b0;
            endcase
        end
        rd_done_c = rd_en_c && (rcnt == AW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= rd_en_c;
            out_last  <= rd_done_c;
            if (rd_en_c) out_idx <= rcnt;
        end
    end

    reorder_ram #(
        .DEPTH (2 * N),
        .AW    (AW + 1),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_addr ({wbank, wr_addr_nat}),
        .wr_data ({in_re, in_im}),
        .rd_en   (rd_en_c),
        .rd_addr ({rbank, rcnt}),
        .rd_data (rd_data)
    );

    assign out_re = rd_data[DW-1:WIDTH];
    assign out_im = rd_data[WIDTH-1:0];

endmodule
